traffic_phase_fsm: RTL and testbench

- Four-way traffic-light phase controller; directly downstream of the 100 MHz → 1 Hz divider.
- Consumes the divider's 1 Hz square wave on `Slow_Clk` and drives the divider's `En`.
- Sequences North, East, South, West through green, yellow and all-red phases on one-second boundaries.
- Drives the lamp outputs and a seconds-remaining count for the display.

---
 rtl/traffic_phase_fsm.sv | 160 ++++++++++++++++
 tb/tb_traffic_phase_fsm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_fsm.sv
// Four-way traffic-light phase controller driven by a 1 Hz tick from the clock divider.
// Optional emergency preemption is compiled in when EMERG_EN is defined.
module traffic_phase_fsm #(
  parameter int GREEN_SEC  = 10,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 2
) (
  input  logic       Clk_In,
  input  logic       Rst_N,
  input  logic       Slow_Clk,
  input  logic       Emerg,
  output logic       Div_En,
  output logic [2:0] Light_N,
  output logic [2:0] Light_E,
  output logic [2:0] Light_S,
  output logic [2:0] Light_W,
  output logic [5:0] Sec_Left,
  output logic [1:0] Dir,
  output logic [1:0] State_Dbg
);

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } phase_e;

  localparam logic [5:0] G_LOAD = 6'(GREEN_SEC - 1);
  localparam logic [5:0] Y_LOAD = 6'(YELLOW_SEC - 1);
  localparam logic [5:0] A_LOAD = 6'(ALLRED_SEC - 1);

  phase_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic        slow_q;
  logic        div_en_q;
  logic [2:0]  light_n_q, light_n_d, light_e_q, light_e_d;
  logic [2:0]  light_s_q, light_s_d, light_w_q, light_w_d;
  logic [5:0]  sec_left_q, sec_left_d;
  logic        tick;
  logic        emerg_s;

`ifdef EMERG_EN
  logic emerg_meta_q, emerg_s_q;

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      emerg_meta_q <= 1'b0;
      emerg_s_q    <= 1'b0;
    end else begin
      emerg_meta_q <= Emerg;
      emerg_s_q    <= emerg_meta_q;
    end
  end

  assign emerg_s = emerg_s_q;
`else
  logic unused_emerg;
  assign unused_emerg = Emerg;
  assign emerg_s      = 1'b0;
`endif

  function automatic logic [2:0] lamp(input phase_e st, input logic [1:0] d,
                                      input logic [1:0] idx);
    if (d == idx && st == GREEN)  return 3'b001;
    if (d == idx && st == YELLOW) return 3'b010;
    return 3'b100;
  endfunction

  always_comb begin
    tick    = Slow_Clk & ~slow_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      GREEN: begin
        if (emerg_s) begin
          state_d = YELLOW;
          cnt_d   = Y_LOAD;
        end else if (tick) begin
          if (cnt_q == 6'd0) begin
            state_d = YELLOW;
            cnt_d   = Y_LOAD;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      YELLOW: begin
        if (tick) begin
          if (cnt_q == 6'd0) begin
            state_d = ALL_RED;
            cnt_d   = A_LOAD;
            dir_d   = dir_q + 2'd1;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      ALL_RED: begin
        // An expired clearance interval is held while the emergency is active.
        if (tick && !(cnt_q == 6'd0 && emerg_s)) begin
          if (cnt_q == 6'd0) begin
            state_d = GREEN;
            cnt_d   = G_LOAD;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      default: begin
        state_d = ALL_RED;
        cnt_d   = A_LOAD;
      end
    endcase

    // Outputs are decoded from the next state so they land with it on one edge.
    light_n_d  = lamp(state_d, dir_d, 2'd0);
    light_e_d  = lamp(state_d, dir_d, 2'd1);
    light_s_d  = lamp(state_d, dir_d, 2'd2);
    light_w_d  = lamp(state_d, dir_d, 2'd3);
    sec_left_d = cnt_d + 6'd1;
  end

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q    <= ALL_RED;
      cnt_q      <= A_LOAD;
      dir_q      <= 2'd0;
      slow_q     <= 1'b0;
      div_en_q   <= 1'b0;
      light_n_q  <= 3'b100;
      light_e_q  <= 3'b100;
      light_s_q  <= 3'b100;
      light_w_q  <= 3'b100;
      sec_left_q <= 6'(ALLRED_SEC);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      slow_q     <= Slow_Clk;
      div_en_q   <= 1'b1;
      light_n_q  <= light_n_d;
      light_e_q  <= light_e_d;
      light_s_q  <= light_s_d;
      light_w_q  <= light_w_d;
      sec_left_q <= sec_left_d;
    end
  end

  assign Div_En    = div_en_q;
  assign Light_N   = light_n_q;
  assign Light_E   = light_e_q;
  assign Light_S   = light_s_q;
  assign Light_W   = light_w_q;
  assign Sec_Left  = sec_left_q;
  assign Dir       = dir_q;
  assign State_Dbg = state_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm: reset, first green, full rotation, mid-phase reset,
// and emergency preemption (expectations follow EMERG_EN).
module tb_traffic_phase_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b0;
  logic       emerg = 1'b0;
  logic       div_en;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic [5:0] sec_left;
  logic [1:0] dir;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  traffic_phase_fsm dut (
    .Clk_In   (clk),
    .Rst_N    (rst_n),
    .Slow_Clk (slow_clk),
    .Emerg    (emerg),
    .Div_En   (div_en),
    .Light_N  (light_n),
    .Light_E  (light_e),
    .Light_S  (light_s),
    .Light_W  (light_w),
    .Sec_Left (sec_left),
    .Dir      (dir),
    .State_Dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_rise();
    slow_clk = 1'b1;
    step();
  endtask

  task automatic tick_fall();
    repeat (9) step();
    slow_clk = 1'b0;
    repeat (10) step();
  endtask

  // st: 0 green, 1 yellow, 2 all-red; packed {N,E,S,W}
  function automatic logic [11:0] lamps_of(input int st, input int d);
    logic [11:0] res;
    for (int i = 0; i < 4; i++) begin
      if (i == d && st == 0)      res[11-3*i -: 3] = 3'b001;
      else if (i == d && st == 1) res[11-3*i -: 3] = 3'b010;
      else                        res[11-3*i -: 3] = 3'b100;
    end
    return res;
  endfunction

  task automatic check_lamps(input string tag, input logic [11:0] exp);
    int nonred;
    logic [11:0] obs;
    obs = {light_n, light_e, light_s, light_w};
    nonred = 0;
    for (int i = 0; i < 4; i++) if (obs[11-3*i -: 3] != 3'b100) nonred++;
    check(tag, obs, exp);
    check({tag, "_nonred"}, 32'(nonred <= 1), 32'd1);
  endtask

  // Expected outputs after tick number kk since reset release (default parameters).
  task automatic check_model(input int kk);
    int m, d, r, st, ed, es;
    if (kk == 0) begin
      st = 2; ed = 0; es = 2;
    end else if (kk == 1) begin
      st = 2; ed = 0; es = 1;
    end else begin
      m = (kk - 2) % 60;
      d = m / 15;
      r = m % 15;
      if (r < 10)      begin st = 0; ed = d;           es = 10 - r; end
      else if (r < 13) begin st = 1; ed = d;           es = 13 - r; end
      else             begin st = 2; ed = (d + 1) % 4; es = 15 - r; end
    end
    check($sformatf("dir_k%0d", kk), dir, ed);
    check($sformatf("sec_k%0d", kk), sec_left, es);
    check_lamps($sformatf("lamps_k%0d", kk), lamps_of(st, ed));
  endtask

  task automatic do_tick();
    tick_rise();
    k++;
    check_model(k);
    tick_fall();
  endtask

`ifdef EMERG_EN
  int          em_sec[6] = '{2, 1, 2, 1, 1, 1};
  int          em_dir[6] = '{0, 0, 1, 1, 1, 1};
  int          em_st[6]  = '{1, 1, 2, 2, 2, 2};
`endif

  initial begin
    // Reset held while Slow_Clk pulses
    repeat (2) step();
    slow_clk = 1'b1;
    repeat (3) step();
    check_lamps("rst_lamps", 12'b100_100_100_100);
    check("rst_sec", sec_left, 2);
    check("rst_div_en", div_en, 0);
    check("rst_dir", dir, 0);
    slow_clk = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("div_en_before_edge", div_en, 0);
    step();
    check("div_en_after_edge", div_en, 1);
    k = 0;
    check_model(0);
    repeat (4) step();

    // First green, with exact one-cycle latency after the sampled edge
    do_tick();
    slow_clk = 1'b1;
    @(negedge clk);
    check("latency_sec_old", sec_left, 1);
    check("latency_n_old", light_n, 3'b100);
    @(posedge clk);
    #1;
    k++;
    check_model(k);
    check("first_green_n", light_n, 3'b001);
    repeat (30) step();
    check("level_hold_sec", sec_left, 10);
    slow_clk = 1'b0;
    repeat (10) step();

    // Full rotation up to tick 62 (N green again after W)
    while (k < 62) do_tick();
    check("wrap_n_green", light_n, 3'b001);

    // Advance to E yellow, then async reset mid-phase
    while (k < 87) do_tick();
    check("e_yellow", light_e, 3'b010);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check_lamps("midrst_lamps", 12'b100_100_100_100);
    check("midrst_dir", dir, 0);
    check("midrst_sec", sec_left, 2);
    check("midrst_div_en", div_en, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("midrst_div_en_up", div_en, 1);
    k = 0;
    check_model(0);
    repeat (4) step();
    while (k < 4) do_tick();

    // Emergency at N green with 7 seconds left
    tick_rise();
    k++;
    check_model(k);
    emerg = 1'b1;
    step();
    step();
`ifdef EMERG_EN
    check("em_sync_n", light_n, 3'b001);
    check("em_sync_sec", sec_left, 7);
    step();
    check("em_n_yellow", light_n, 3'b010);
    check("em_sec3", sec_left, 3);
    check("em_dir0", dir, 0);
`else
    step();
    check_model(k);
`endif
    tick_fall();
    for (int i = 0; i < 6; i++) begin
      tick_rise();
      k++;
`ifdef EMERG_EN
      check($sformatf("em_sec_%0d", i), sec_left, em_sec[i]);
      check($sformatf("em_dir_%0d", i), dir, em_dir[i]);
      check_lamps($sformatf("em_lamps_%0d", i), lamps_of(em_st[i], em_dir[i]));
`else
      check_model(k);
`endif
      tick_fall();
    end
    emerg = 1'b0;
    repeat (3) step();
    tick_rise();
    k++;
`ifdef EMERG_EN
    check("em_release_e", light_e, 3'b001);
    check("em_release_sec", sec_left, 10);
    check("em_release_dir", dir, 1);
    check("em_release_n", light_n, 3'b100);
`else
    check_model(k);
`endif
    tick_fall();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
